// File: rtl/id_ex_stage.sv
// id_ex_stage -- decode-to-execute pipeline register for the 5-stage MIPS core.
//
// Captures decode-stage operands and control every cycle and presents them to
// the 3-bit-op ALU in the execute stage. Supports hold (stall_e) and bubble
// insertion (flush_e). Update priority per rising edge: rst > flush_e >
// stall_e > load. rst and flush_e both clear every stage register to 0.
//
// Optional feature (macro ID_EX_FORWARD_EN):
//   defined   -> EX operands are forwarded from the M and W stages (M first).
//   undefined -> operands come straight from the stage registers; all M/W
//                inputs are ignored and hazards must be handled by stalling.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall_e, flush_e          hold / bubble controls
//   rd1_d, rd2_d, signimm_d   decode-stage operands (DW bits)
//   rs_d, rt_d, rd_d          decode-stage register indices (RW bits)
//   alucontrol_d, alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d
//                             decode-stage control
//   aluout_m, writereg_m, regwrite_m   M-stage forwarding source
//   result_w, writereg_w, regwrite_w   W-stage forwarding source
//   num1_e, num2_e, op_e      ALU operands and op
//   writedata_e               forwarded rt value for stores
//   writereg_e                destination index (rd if regdst else rt)
//   regwrite_e, memtoreg_e, memwrite_e  registered control
//   rs_e, rt_e                registered indices for the hazard unit
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_e,
  input  logic          flush_e,
  input  logic [DW-1:0] rd1_d,
  input  logic [DW-1:0] rd2_d,
  input  logic [DW-1:0] signimm_d,
  input  logic [RW-1:0] rs_d,
  input  logic [RW-1:0] rt_d,
  input  logic [RW-1:0] rd_d,
  input  logic [2:0]    alucontrol_d,
  input  logic          alusrc_d,
  input  logic          regdst_d,
  input  logic          regwrite_d,
  input  logic          memtoreg_d,
  input  logic          memwrite_d,
  input  logic [DW-1:0] aluout_m,
  input  logic [RW-1:0] writereg_m,
  input  logic          regwrite_m,
  input  logic [DW-1:0] result_w,
  input  logic [RW-1:0] writereg_w,
  input  logic          regwrite_w,
  output logic [DW-1:0] num1_e,
  output logic [DW-1:0] num2_e,
  output logic [2:0]    op_e,
  output logic [DW-1:0] writedata_e,
  output logic [RW-1:0] writereg_e,
  output logic          regwrite_e,
  output logic          memtoreg_e,
  output logic          memwrite_e,
  output logic [RW-1:0] rs_e,
  output logic [RW-1:0] rt_e
);

  logic [DW-1:0] rd1_q, rd2_q, signimm_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic [2:0]    alucontrol_q;
  logic          alusrc_q, regdst_q, regwrite_q, memtoreg_q, memwrite_q;

  // A flush is a bubble: op 000, no writes, indices 0 -- same as reset.
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      rd1_q        <= '0;
      rd2_q        <= '0;
      signimm_q    <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alucontrol_q <= '0;
      alusrc_q     <= 1'b0;
      regdst_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
    end else if (!stall_e) begin
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      signimm_q    <= signimm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      alucontrol_q <= alucontrol_d;
      alusrc_q     <= alusrc_d;
      regdst_q     <= regdst_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memwrite_q   <= memwrite_d;
    end
  end

  logic [DW-1:0] src_a, src_b;

`ifdef ID_EX_FORWARD_EN
  // Register 0 is hard-wired zero, so a write to it is never forwarded.
  // M is younger than W, so it wins when both match.
  logic m_ok, w_ok;
  assign m_ok = regwrite_m && (writereg_m != '0);
  assign w_ok = regwrite_w && (writereg_w != '0);

  always_comb begin
    src_a = rd1_q;
    if (m_ok && (writereg_m == rs_q))      src_a = aluout_m;
    else if (w_ok && (writereg_w == rs_q)) src_a = result_w;
  end

  always_comb begin
    src_b = rd2_q;
    if (m_ok && (writereg_m == rt_q))      src_b = aluout_m;
    else if (w_ok && (writereg_w == rt_q)) src_b = result_w;
  end
`else
  assign src_a = rd1_q;
  assign src_b = rd2_q;

  // M/W forwarding sources are intentionally unused in this build.
  logic unused_fwd;
  assign unused_fwd = ^{aluout_m, writereg_m, regwrite_m,
                        result_w, writereg_w, regwrite_w};
`endif

  assign num1_e      = src_a;
  assign writedata_e = src_b;
  assign num2_e      = alusrc_q ? signimm_q : src_b;
  assign writereg_e  = regdst_q ? rd_q : rt_q;
  assign op_e        = alucontrol_q;
  assign regwrite_e  = regwrite_q;
  assign memtoreg_e  = memtoreg_q;
  assign memwrite_e  = memwrite_q;
  assign rs_e        = rs_q;
  assign rt_e        = rt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage MIPS core.
- Sits directly upstream of the 3-bit-op ALU.
- Captures decode-stage operands and control each cycle.
- Supports stall (hold) and flush (bubble).
- Resolves EX-operand data hazards by forwarding from the M and W stages, then drives the ALU's num1/num2/op inputs.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- stall_e  in  1  hold all stage registers
- flush_e  in  1  load a bubble
- rd1_d  in  DW  register-file read data for rs
- rd2_d  in  DW  register-file read data for rt
- signimm_d  in  DW  sign-extended immediate
- rs_d, rt_d, rd_d  in  RW each  register indices
- alucontrol_d  in  3  ALU op code
- alusrc_d  in  1  1 = num2 is the immediate
- regdst_d  in  1  1 = destination is rd, else rt
- regwrite_d, memtoreg_d, memwrite_d  in  1 each  control bits
- aluout_m  in  DW  M-stage ALU result
- writereg_m  in  RW  M-stage destination index
- regwrite_m  in  1  M-stage write enable
- result_w  in  DW  W-stage writeback value
- writereg_w  in  RW  W-stage destination index
- regwrite_w  in  1  W-stage write enable
- num1_e  out  DW  ALU operand A
- num2_e  out  DW  ALU operand B
- op_e  out  3  ALU op
- writedata_e  out  DW  forwarded rt value for store
- writereg_e  out  RW  destination index
- regwrite_e, memtoreg_e, memwrite_e  out  1 each  registered control
- rs_e, rt_e  out  RW each  registered indices for the hazard unit

Behaviour:
- One clock domain. All state updates on the rising edge of clk.
- Update priority per edge: rst > flush_e > stall_e > load.
  - rst: every stage register cleared to 0.
  - flush_e: every stage register cleared to 0, i.e. a bubble (op 000, no writes, indices 0).
  - flush_e and stall_e both high: flush wins.
  - stall_e alone: all registers hold.
  - otherwise: all registers load their *_d inputs.
- Latency: *_d inputs appear as E-stage state 1 cycle after the loading edge.
- Registered quantities: rd1, rd2, signimm, rs, rt, rd, alucontrol, alusrc, regdst, regwrite, memtoreg, memwrite.
- Control-only outputs are driven straight from the registers: op_e, regwrite_e, memtoreg_e, memwrite_e, rs_e, rt_e.
- writereg_e = regdst ? rd : rt (combinational on registered values).
- Forward select A (combinational), first match wins:
  - M: regwrite_m && writereg_m != 0 && writereg_m == rs_e.
  - else W: regwrite_w && writereg_w != 0 && writereg_w == rs_e.
  - else the registered rd1.
  - M has priority over W when both match.
- Forward select B: same rules against rt_e, choosing between aluout_m, result_w and the registered rd2.
- srcA = selected A value; num1_e = srcA.
- writedata_e = forwarded B value; unaffected by alusrc.
- num2_e = alusrc ? registered signimm : forwarded B value.
- Register index 0 is never forwarded; the registered value passes through.
- Reset values (the forwarding muxes are combinational, so these follow from the cleared registers):
  - All registered outputs are 0.
  - num1_e and num2_e are 0 only when no forwarding match exists. After reset rs_e = rt_e = 0, so no match is possible and they are 0.
- alucontrol code 011 passes through unchanged; no check is made.
- No arithmetic is performed in this stage; widths pass through unchanged.
- During a stall, forwarding stays live: if M/W contents change, num1_e/num2_e may change while the registers hold.
- rst asserted mid-stall or mid-flush: reset applies at that edge.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding muxes as described under Behaviour.
- Undefined:
  - num1_e = registered rd1.
  - writedata_e = registered rd2.
  - num2_e = alusrc ? signimm : rd2.
  - aluout_m, writereg_m, regwrite_m, result_w, writereg_w, regwrite_w are ignored.
  - Hazards are then resolved by stalling elsewhere.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero *_d → all outputs 0; one cycle after rst deasserts with stall_e=flush_e=0 → outputs reflect *_d.
- Load and immediate mux:
  - Load rd1_d=0x10, rd2_d=0x20, signimm_d=0xFFFFFFFC, alusrc_d=1, alucontrol_d=010 → next cycle num1_e=0x10, num2_e=0xFFFFFFFC, op_e=010, writedata_e=0x20.
  - Same with alusrc_d=0 → num2_e=0x20.
- Forwarding priority: rs_e=rt_e=8, alusrc=0, regwrite_m=1 writereg_m=8 aluout_m=0xAAAA, regwrite_w=1 writereg_w=8 result_w=0x5555 → num1_e=num2_e=0xAAAA; then regwrite_m=0 → 0x5555.
- Zero register: rs_e=0, writereg_m=0, regwrite_m=1, aluout_m=0x1234, registered rd1=0x77 → num1_e=0x77.
- Stall/flush:
  - stall_e=1 for 3 cycles while *_d changes → E registers unchanged.
  - stall_e=1 with flush_e=1 → bubble: op_e=000, regwrite_e=memwrite_e=0.
- writereg select: rt_d=9, rd_d=17; regdst_d=1 → writereg_e=17; regdst_d=0 → 9.
